mem_addr_responder: RTL

- Memory-side responder for the CPU address bus: accepts address requests from the CPU/PC/IR side and returns read data or write acknowledgements.
- Sits between the CPU-side address/data drivers and the on-chip word store.
- Has a valid/ready request channel, a fixed configurable access latency and a valid/ready response channel.
- Decodes addresses against the implemented depth, flags out-of-range accesses and counts them.

---
 rtl/mem_addr_responder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_addr_responder.sv
// Memory-side responder for the CPU address bus: valid/ready request channel,
// fixed access latency, valid/ready response channel and out-of-range error counting.
module mem_addr_responder #(
    parameter int ADDR_SIZE = 19,
    parameter int DATA_SIZE = 19,
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic                 req_we,
    input  logic [DATA_SIZE-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_SIZE-1:0] resp_rdata,
    output logic                 resp_err,
    output logic                 busy,
    output logic [7:0]           err_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_SIZE:0] DEPTH_W  = (ADDR_SIZE+1)'(DEPTH);
    localparam logic [3:0]         CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_SIZE-1:0]  addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_SIZE-1:0]  wdata_q, wdata_d;
    logic [DATA_SIZE-1:0]  rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic [DATA_SIZE-1:0]  mem [DEPTH];
    logic [IDX_W-1:0]      idx;
    logic                  in_range;
    logic                  mem_we;

    // Full address width takes part in the range check, so high bits never alias.
    assign in_range = ({1'b0, addr_q} < DEPTH_W);
    assign idx      = addr_q[IDX_W-1:0];
    assign mem_we   = (state_q == WAIT) && (cnt_q == 4'd0) && in_range && we_q;

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign err_count  = err_cnt_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (in_range) begin
                        rdata_d = we_q ? '0 : mem[idx];
                        err_d   = 1'b0;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage is deliberately unreset; reset forces IDLE so a pending write is dropped.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule
